rom_wave_reader: RTL and testbench
==================================

ROM_WAVE_READER -- requirements
Module: rom_wave_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample/ROM data width.
REQ-002 SHALL have parameter DEPTH, default 64, ROM entries; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter PHASE_W, default 16, phase accumulator width; PHASE_W >= AW.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin generation.
REQ-007 SHALL have port stop  input  1  one-cycle request to end generation.
REQ-008 SHALL have port step  input  PHASE_W  phase increment, sampled on accepted start.
REQ-009 SHALL have port rom_en  output  1  ROM read enable.
REQ-010 SHALL have port rom_addr  output  AW  ROM read address.
REQ-011 SHALL have port rom_data  input  WIDTH  ROM read data, valid 1 cycle after rom_en.
REQ-012 SHALL have port sample  output  WIDTH  output sample.
REQ-013 SHALL have port sample_valid  output  1  sample holds valid data.
REQ-014 SHALL have port sample_ready  input  1  downstream accepts sample.
REQ-015 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse on phase carry-out.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN.
REQ-018 IDLE->RUN on start=1 and stop=0; phase cleared to 0, step latched; start=1 with stop=1 in IDLE SHALL stay IDLE.
REQ-019 start in RUN or DRAIN SHALL be ignored.
REQ-020 RUN->DRAIN on stop=1; no rom_en asserted from that cycle on.
REQ-021 DRAIN->IDLE when in-flight read count and buffer occupancy are both 0.
REQ-022 rom_addr SHALL be combinationally phase[PHASE_W-1:PHASE_W-AW].
REQ-023 A read is issued (rom_en=1) in RUN, stop=0, when occupancy + inflight - pop < 2, pop = sample_valid & sample_ready.
REQ-024 On each issued read, phase <= phase + step modulo 2^PHASE_W; phase SHALL NOT change otherwise.
REQ-025 wrap SHALL pulse the cycle after an issued read whose phase addition carries out of bit PHASE_W-1.
REQ-026 rom_data SHALL be captured 1 cycle after each issued read into a 2-entry FIFO; sample/sample_valid present the FIFO head.
REQ-027 sample SHALL remain stable while sample_valid=1 and sample_ready=0; no sample lost or duplicated.
REQ-028 With sample_ready held 1, SHALL sustain one sample per cycle after 2-cycle start-up latency (start -> first sample_valid).
REQ-029 step=0 SHALL repeatedly read address 0; wrap never pulses.
REQ-030 Samples SHALL appear in issue order.

Reset
REQ-031 rst=1 SHALL force state IDLE, phase 0, latched step 0, inflight 0, FIFO empty, rom_en 0, sample 0, sample_valid 0, busy 0, wrap 0.
REQ-032 rst SHALL take priority over start/stop and abort any in-flight read; its data SHALL be discarded.

Verification
REQ-033 DEPTH=64, PHASE_W=16, step=0x0400, start, ready=1 -> rom_addr 0,1,...,63,0 on consecutive cycles; samples = mem[0..63] in order; wrap pulses once after address-63 issue.
REQ-034 step=0x0200, ready=1 -> each address read twice (0,0,1,1,...); wrap every 128 issues.
REQ-035 RUN, ready=0 for 5 cycles -> exactly 2 reads issued then rom_en=0; sample/sample_valid stable; on ready=1 stream resumes with no gap or loss.
REQ-036 stop after 10 issues, ready=0 -> busy stays 1 (DRAIN); after ready=1, remaining buffered samples delivered, then busy=0, IDLE.
REQ-037 rst asserted mid-RUN with valid sample pending -> next cycle all outputs at reset values; next start restarts from address 0.
REQ-038 start and stop same cycle in IDLE -> busy stays 0, rom_en never asserted.

Source files
------------

// File: rtl/rom_wave_reader_if.sv
// Control, ROM read port and sample stream of the wavetable reader, bundled.
// The reader drives the ROM side and the sample stream through "master".
interface rom_wave_reader_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int PHASE_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] step;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [WIDTH-1:0]   rom_data;
    logic [WIDTH-1:0]   sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;
    logic               wrap;

    modport master (
        input  start, stop, step, rom_data, sample_ready,
        output rom_en, rom_addr, sample, sample_valid, busy, wrap
    );

    modport slave (
        output start, stop, step, rom_data, sample_ready,
        input  rom_en, rom_addr, sample, sample_valid, busy, wrap
    );
endinterface

// File: rtl/rom_wave_reader.sv
// Phase-accumulator wavetable reader: walks a 1-cycle-latency ROM by a latched
// step and streams the read data through a 2-entry FIFO with valid/ready.
module rom_wave_reader #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    rom_wave_reader_if.master  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] step_reg;
    logic               inflight_reg;
    logic               wrap_reg;
    logic [WIDTH-1:0]   fifo_mem_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;

    logic               pop;
    logic               push;
    logic               issue;
    logic [PHASE_W:0]   phase_sum;

    assign pop  = (count_reg != 2'd0) && bus.sample_ready;
    assign push = inflight_reg;

    // Never let buffered plus outstanding data exceed the two FIFO slots.
    assign issue = !rst && (state_reg == RUN) && !bus.stop &&
                   (({1'b0, count_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

    assign phase_sum = {1'b0, phase_reg} + {1'b0, step_reg};

    assign bus.rom_en       = issue;
    assign bus.rom_addr     = phase_reg[PHASE_W-1 -: AW];
    assign bus.sample_valid = (count_reg != 2'd0);
    assign bus.sample       = (count_reg != 2'd0) ? fifo_mem_reg[rd_ptr_reg] : '0;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.wrap         = wrap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            step_reg     <= '0;
            inflight_reg <= 1'b0;
            wrap_reg     <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            inflight_reg <= issue;
            wrap_reg     <= issue & phase_sum[PHASE_W];
            if (issue) begin
                phase_reg <= phase_sum[PHASE_W-1:0];
            end

            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};

            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_reg <= RUN;
                        phase_reg <= '0;
                        step_reg  <= bus.step;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight_reg && (count_reg == 2'd0)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ROM data arrives the cycle after the read, so capture is keyed on inflight.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk) begin
            if (rst) begin
                fifo_mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                fifo_mem_reg[gi] <= bus.rom_data;
            end
        end
    end
endmodule

// File: tb/tb_rom_wave_reader.sv
// Scoreboard bench for rom_wave_reader: stimulus queues expected ROM issues and
// samples, a negedge monitor pops and compares as the DUT presents them.
module tb_rom_wave_reader;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int PHASE_W = 16;

    typedef struct packed {
        logic [5:0] addr;
        logic       wrap;
    } iss_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rom_wave_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PHASE_W(PHASE_W)) bus();

    rom_wave_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PHASE_W(PHASE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    iss_t        exp_iss_q[$];
    logic [31:0] exp_smp_q[$];
    int          total = 0;
    int          bad = 0;
    int          issue_cnt = 0;
    int          wrap_cnt = 0;
    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] rom_val(input int a);
        return 32'hC0DE_0000 + 32'(a * 17);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rom_val(i);
    end

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= mem[bus.rom_addr];
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: issue order, wrap timing, sample order and hold stability.
    initial begin
        logic        pend_wrap;
        logic        hold;
        logic [31:0] hold_smp;
        iss_t        e;
        logic [31:0] s;
        pend_wrap = 1'b0;
        hold      = 1'b0;
        hold_smp  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_wrap = 1'b0;
                hold      = 1'b0;
            end else begin
                check_eq("wrap", 32'(bus.wrap), 32'(pend_wrap));
                if (bus.wrap) wrap_cnt++;
                if (hold) begin
                    check_eq("hold_sample", bus.sample, hold_smp);
                    check_eq("hold_valid", 32'(bus.sample_valid), 32'd1);
                end
                pend_wrap = 1'b0;
                if (bus.rom_en) begin
                    issue_cnt++;
                    if (exp_iss_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: got addr %0d want no read at %0t", bus.rom_addr, $time);
                    end else begin
                        e = exp_iss_q.pop_front();
                        check_eq("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
                        pend_wrap = e.wrap;
                    end
                end
                if (bus.sample_valid && bus.sample_ready) begin
                    if (exp_smp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_sample: got %h want no sample at %0t", bus.sample, $time);
                    end else begin
                        s = exp_smp_q.pop_front();
                        check_eq("sample", bus.sample, s);
                        $display("sample %h expected %h", bus.sample, s);
                    end
                end
                hold     = bus.sample_valid && !bus.sample_ready;
                hold_smp = bus.sample;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected issue/sample list for n reads from phase 0 (AW=6 -> phase[15:10]).
    task automatic push_run(input logic [15:0] st, input int n);
        logic [16:0] ph;
        logic [16:0] sum;
        iss_t        e;
        ph = '0;
        for (int k = 0; k < n; k++) begin
            e.addr = ph[15:10];
            sum    = ph + {1'b0, st};
            e.wrap = sum[16];
            exp_iss_q.push_back(e);
            exp_smp_q.push_back(rom_val(int'(ph[15:10])));
            ph = {1'b0, sum[15:0]};
        end
    endtask

    task automatic start_run(input logic [15:0] st);
        bus.step  = st;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_issues(input int base, input int n);
        for (int i = 0; i < 3000; i++) begin
            if (issue_cnt - base >= n) break;
            tick();
        end
        check_eq("issue_count", 32'(issue_cnt - base), 32'(n));
    endtask

    task automatic stop_pulse();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_idle_and_drain();
        for (int i = 0; i < 500; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check_eq("drain_to_idle", 32'(bus.busy), 32'd0);
        tick();
        check_eq("pending_issues", 32'(exp_iss_q.size()), 32'd0);
        check_eq("pending_samples", 32'(exp_smp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
        check_eq({tag, "_sample"}, bus.sample, 32'd0);
        check_eq({tag, "_rom_en"}, 32'(bus.rom_en), 32'd0);
        check_eq({tag, "_wrap"}, 32'(bus.wrap), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wbase;
        int lat;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.step         = '0;
        bus.sample_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Full table sweep, addresses 0..63,0 and a single wrap; start latency 2.
        bus.sample_ready = 1'b1;
        base  = issue_cnt;
        wbase = wrap_cnt;
        push_run(16'h0400, 65);
        start_run(16'h0400);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.sample_valid) break;
            lat++;
            tick();
        end
        check_eq("start_latency", 32'(lat), 32'd2);
        wait_issues(base, 65);
        stop_pulse();
        wait_idle_and_drain();
        check_eq("wrap_count_step400", 32'(wrap_cnt - wbase), 32'd1);

        // Half step: each address twice, one wrap in 130 issues.
        base  = issue_cnt;
        wbase = wrap_cnt;
        push_run(16'h0200, 130);
        start_run(16'h0200);
        wait_issues(base, 130);
        stop_pulse();
        wait_idle_and_drain();
        check_eq("wrap_count_step200", 32'(wrap_cnt - wbase), 32'd1);

        // Backpressure: only two reads may be outstanding.
        bus.sample_ready = 1'b0;
        base = issue_cnt;
        push_run(16'h0400, 8);
        start_run(16'h0400);
        repeat (5) tick();
        check_eq("bp_issue_count", 32'(issue_cnt - base), 32'd2);
        check_eq("bp_rom_en", 32'(bus.rom_en), 32'd0);
        check_eq("bp_valid", 32'(bus.sample_valid), 32'd1);
        bus.sample_ready = 1'b1;
        wait_issues(base, 8);
        stop_pulse();
        wait_idle_and_drain();

        // Stop with downstream stalled: DRAIN holds busy until buffer empties.
        bus.sample_ready = 1'b1;
        base = issue_cnt;
        push_run(16'h0400, 10);
        start_run(16'h0400);
        wait_issues(base, 10);
        bus.sample_ready = 1'b0;
        stop_pulse();
        repeat (4) tick();
        check_eq("drain_busy", 32'(bus.busy), 32'd1);
        check_eq("drain_valid", 32'(bus.sample_valid), 32'd1);
        check_eq("drain_no_issue", 32'(issue_cnt - base), 32'd10);
        bus.sample_ready = 1'b1;
        wait_idle_and_drain();

        // Reset mid-run with a sample pending, then restart from address 0.
        bus.sample_ready = 1'b0;
        push_run(16'h0400, 4);
        start_run(16'h0400);
        repeat (4) tick();
        check_eq("pre_reset_valid", 32'(bus.sample_valid), 32'd1);
        rst = 1'b1;
        exp_iss_q.delete();
        exp_smp_q.delete();
        tick();
        rst = 1'b0;
        check_reset_outputs("midrun_reset");
        bus.sample_ready = 1'b1;
        base = issue_cnt;
        push_run(16'h0400, 3);
        start_run(16'h0400);
        wait_issues(base, 3);
        stop_pulse();
        wait_idle_and_drain();

        // Start and stop together in IDLE must be ignored.
        base = issue_cnt;
        bus.step  = 16'h0400;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("startstop_busy", 32'(bus.busy), 32'd0);
            check_eq("startstop_rom_en", 32'(bus.rom_en), 32'd0);
            tick();
        end
        check_eq("startstop_issues", 32'(issue_cnt - base), 32'd0);

        // Zero step: address 0 repeatedly, never a wrap.
        base  = issue_cnt;
        wbase = wrap_cnt;
        push_run(16'h0000, 6);
        start_run(16'h0000);
        wait_issues(base, 6);
        stop_pulse();
        wait_idle_and_drain();
        check_eq("wrap_count_step0", 32'(wrap_cnt - wbase), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
